pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//  Soft-start/soft-stop sequencer for the 7-bit PWM duty-cycle input.
//  - Walks its duty output toward a requested target in bounded steps.
//  - Updates the duty only at PWM period boundaries, so no period ever sees a mid-period duty change.
//  - Forces the duty to 0 immediately on fault.
//  - Sits between the user inputs (target, enable, fault) and the pwm core's dc port; dc_out drives dc directly.
// PARAMETERS
//  DC_W      7    width of duty-cycle values
//  DC_MAX    100  largest legal duty; larger targets are clamped to this value
//  STEP      4    maximum duty change per step tick, 1..DC_MAX
//  PRESCALE  8    PWM periods per step tick, >=1; the counter is $clog2(PRESCALE+1) bits
// PORTS
//  clk         in   1     single clock
//  reset       in   1     synchronous, active-high
//  en          in   1     level; 1 = run at target, 0 = ramp down to 0
//  target      in   DC_W  requested duty, sampled every cycle
//  period_end  in   1     1-cycle pulse from the pwm core on the last cycle of each period
//  fault       in   1     level; any 1 forces the FAULT state
//  dc_out      out  DC_W  registered duty to the pwm core
//  busy        out  1     state is RAMP or STOP
//  at_target   out  1     state is HOLD
//  fault_act   out  1     state is FAULT
// BEHAVIOUR
//  - Reset: state=IDLE, dc_out=0, tgt_q=0, presc=0; busy, at_target and fault_act all 0.
//    Reset overrides every other input.
//  - tgt_q <= min(target, DC_MAX) every cycle. A retarget mid-ramp is legal; the direction is re-evaluated at each tick.
//  - Step tick: tick = period_end && (presc == PRESCALE-1).
//    - presc increments on each period_end and wraps to 0 on tick.
//    - presc clears on entry to RAMP or STOP.
//    - Ticks are only used in RAMP and STOP.
//  - Step rule on a tick, toward goal g:
//    - dc_out < g: dc_out += min(STEP, g - dc_out).
//    - dc_out > g: dc_out -= min(STEP, dc_out - g).
//    - dc_out never overshoots g and never goes outside 0..DC_MAX. No wrap-around.
//  - FSM; fault is checked first in every state:
//    - IDLE: dc_out held at 0. en=1 -> RAMP.
//    - RAMP (g = tgt_q):
//      - en=0 -> STOP.
//      - Otherwise step on tick; when dc_out == tgt_q after the step (or already equal) -> HOLD.
//    - HOLD: dc_out frozen.
//      - en=0 -> STOP.
//      - tgt_q != dc_out -> RAMP; the first step comes on the next tick.
//    - STOP (g = 0): step down on tick; dc_out == 0 -> IDLE.
//      - en=1 -> RAMP, keeping the current dc_out with no jump.
//    - FAULT: dc_out=0 in the same cycle the state is entered, i.e. 1 clk after fault rises.
//      - Leaves to IDLE only when fault=0 AND en=0 (the operator must re-arm).
//  - Simultaneous events: reset > fault > en=0 > retarget.
//    - An en fall and a target change in the same cycle: the en fall wins.
//    - A tick in the same cycle as the fault: the tick is ignored.
//  - target=0 with en=1: ramps to 0 and sits in HOLD; the state is not IDLE.
//  - Latency: a step becomes visible on dc_out 1 clk after the period_end that caused the tick,
//    so the pwm core sees the new duty from the first cycle of the next period.
//  - Status outputs are decoded from the registered state, so they are glitch-free and change in the same cycle as the state.
// STRUCTURE
//  - Shared package pwm_ctrl_pkg holds:
//    - state enum: IDLE, RAMP, HOLD, STOP, FAULT
//    - DC_W = 7 and DC_MAX = 100 defaults
//  - Sub-module pwm_step_prescaler (period_end counter -> tick, with a synchronous clear).
//  - FSM, clamp and step arithmetic stay in this module. The step arithmetic is done at DC_W+1 bits so that compares never overflow.
// TESTING
//  Defaults; period_end every 10 clk.
//  1. Ramp up: en=1, target=20 -> dc_out goes 4,8,12,16,20, one step per 8 periods; then at_target=1 and busy=0.
//  2. Clamp and no overshoot: target=127 -> dc_out stops at 100. Then target=98 -> the next tick gives exactly 98.
//  3. Mid-ramp retarget: target 60 -> 10 while dc_out=24 -> next ticks give 20, 16, 12, 10, then HOLD.
//  4. Soft stop: en=0 in HOLD at dc=10 -> 6, 2, 0, then IDLE. en=1 re-asserted at dc=6 -> RAMP continues up from 6.
//  5. Fault: fault=1 at dc=50 -> next clk dc_out=0 and fault_act=1.
//     fault=0 with en=1 -> stays in FAULT; en=0 -> IDLE.
//  6. Reset mid-ramp at dc=32 -> next clk all outputs 0 and IDLE. Also: a fault pulse coincident with a tick -> no step is applied.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the PWM duty-cycle ramp controller.
package pwm_ctrl_pkg;

    localparam int DC_W_DEFAULT   = 7;
    localparam int DC_MAX_DEFAULT = 100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

endpackage

// File: rtl/pwm_step_prescaler.sv
// Counts PWM period boundaries and emits a step tick every PRESCALE periods.
module pwm_step_prescaler #(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic period_end,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE + 1);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] presc_q, presc_d;

    assign tick = period_end && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (period_end) begin
            presc_d = tick ? '0 : presc_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: walks the PWM duty toward a target in bounded
// steps applied only at period boundaries, and forces duty to 0 on fault.
//   state | meaning
//   IDLE  | duty held at 0, waiting for en
//   RAMP  | stepping toward the clamped target
//   HOLD  | duty equals target, frozen
//   STOP  | stepping down toward 0 after en fell
//   FAULT | duty forced to 0 until fault clears and en is dropped
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DC_W     = DC_W_DEFAULT,
    parameter int DC_MAX   = DC_MAX_DEFAULT,
    parameter int STEP     = 4,
    parameter int PRESCALE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [DC_W-1:0] target,
    input  logic            period_end,
    input  logic            fault,
    output logic [DC_W-1:0] dc_out,
    output logic            busy,
    output logic            at_target,
    output logic            fault_act
);

    localparam logic [DC_W-1:0] DC_MAX_V = DC_W'(DC_MAX);
    localparam logic [DC_W:0]   STEP_V   = (DC_W + 1)'(STEP);

    state_t          state_q, state_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic [DC_W-1:0] tgt_q, tgt_d;
    logic            tick;
    logic            presc_clr;

    logic [DC_W-1:0] goal;
    logic [DC_W:0]   cur_w, goal_w, diff_w, amt_w, next_w;
    logic [DC_W-1:0] stepped;

    pwm_step_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk        (clk),
        .reset      (reset),
        .period_end (period_end),
        .clear      (presc_clr),
        .tick       (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dc_q    <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            dc_q    <= dc_d;
            tgt_q   <= tgt_d;
        end
    end

    // One bounded step toward the goal; extra bit keeps the compares overflow-free.
    always_comb begin
        tgt_d  = (target > DC_MAX_V) ? DC_MAX_V : target;
        goal   = (state_q == ST_STOP) ? '0 : tgt_q;
        cur_w  = {1'b0, dc_q};
        goal_w = {1'b0, goal};
        if (cur_w < goal_w) begin
            diff_w = goal_w - cur_w;
            amt_w  = (diff_w > STEP_V) ? STEP_V : diff_w;
            next_w = cur_w + amt_w;
        end else begin
            diff_w = cur_w - goal_w;
            amt_w  = (diff_w > STEP_V) ? STEP_V : diff_w;
            next_w = cur_w - amt_w;
        end
        stepped = DC_W'(next_w);
    end

    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        if (fault) begin
            state_d = ST_FAULT;
            dc_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dc_d = '0;
                    if (en) state_d = ST_RAMP;
                end
                ST_RAMP: begin
                    if (!en) begin
                        state_d = ST_STOP;
                    end else if (tick) begin
                        dc_d = stepped;
                        if (stepped == tgt_q) state_d = ST_HOLD;
                    end else if (dc_q == tgt_q) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!en) state_d = ST_STOP;
                    else if (tgt_q != dc_q) state_d = ST_RAMP;
                end
                ST_STOP: begin
                    if (en) begin
                        state_d = ST_RAMP;
                    end else if (tick) begin
                        dc_d = stepped;
                        if (stepped == '0) state_d = ST_IDLE;
                    end else if (dc_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    dc_d = '0;
                    if (!en) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    dc_d    = '0;
                end
            endcase
        end
        // A fresh RAMP/STOP always waits a full prescale interval before its first step.
        presc_clr = ((state_d == ST_RAMP) || (state_d == ST_STOP)) && (state_d != state_q);
    end

    always_comb begin
        dc_out    = dc_q;
        busy      = (state_q == ST_RAMP) || (state_q == ST_STOP);
        at_target = (state_q == ST_HOLD);
        fault_act = (state_q == ST_FAULT);
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: period_end every 10 clk, step tick every 8 periods.
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       reset, en, period_end, fault;
    logic [6:0] target, dc_out;
    logic       busy, at_target, fault_act;

    int n_vec = 0;
    int n_err = 0;
    int pcnt  = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .DC_W (7), .DC_MAX (100), .STEP (4), .PRESCALE (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .target     (target),
        .period_end (period_end),
        .fault      (fault),
        .dc_out     (dc_out),
        .busy       (busy),
        .at_target  (at_target),
        .fault_act  (fault_act)
    );

    // pcnt reads 0 on the negedge right after the period_end posedge.
    initial begin
        period_end = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pcnt       = (pcnt == 9) ? 0 : pcnt + 1;
            period_end = (pcnt == 9);
        end
    end

    task automatic wait_change(input logic [6:0] prev, output int cyc, output bit to);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (dc_out === prev && cyc < 200);
        to = (dc_out === prev);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; fault = 1'b1; target = 7'd50;
        repeat (3) @(negedge clk);
        n_vec++; if (dc_out !== 7'd0) begin n_err++; $display("FAIL reset_dc got=%0d exp=0", dc_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (at_target !== 1'b0) begin n_err++; $display("FAIL reset_at_target got=%b exp=0", at_target); end
        n_vec++; if (fault_act !== 1'b0) begin n_err++; $display("FAIL reset_fault_act got=%b exp=0", fault_act); end
        en = 1'b0; fault = 1'b0; target = 7'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0 || dc_out !== 7'd0) begin n_err++; $display("FAIL idle_after_reset busy=%b dc=%0d exp busy=0 dc=0", busy, dc_out); end
    endtask

    task automatic test_ramp_up();
        logic [6:0] prev, exp;
        int cyc; bit to;
        en = 1'b1; target = 7'd20;
        @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ramp_enter_busy got=%b exp=1", busy); end
        prev = 7'd0;
        for (int i = 1; i <= 5; i++) begin
            wait_change(prev, cyc, to);
            exp = 7'(4 * i);
            n_vec++; if (to || dc_out !== exp) begin n_err++; $display("FAIL ramp_up_step%0d got=%0d exp=%0d timeout=%0d", i, dc_out, exp, to); end
            n_vec++; if (pcnt != 0) begin n_err++; $display("FAIL ramp_up_latency%0d pcnt=%0d exp=0", i, pcnt); end
            if (i > 1) begin
                n_vec++; if (cyc != 80) begin n_err++; $display("FAIL ramp_up_spacing%0d got=%0d exp=80", i, cyc); end
            end
            prev = dc_out;
        end
        n_vec++; if (at_target !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ramp_up_hold at_target=%b busy=%b exp 1/0", at_target, busy); end
    endtask

    task automatic test_clamp();
        logic [6:0] prev, exp;
        int cyc; bit to;
        target = 7'd127;
        prev = 7'd20;
        for (int i = 1; i <= 20; i++) begin
            wait_change(prev, cyc, to);
            exp = 7'(20 + 4 * i);
            n_vec++; if (to || dc_out !== exp) begin n_err++; $display("FAIL clamp_step%0d got=%0d exp=%0d timeout=%0d", i, dc_out, exp, to); end
            prev = dc_out;
        end
        repeat (100) @(negedge clk);
        n_vec++; if (dc_out !== 7'd100 || at_target !== 1'b1) begin n_err++; $display("FAIL clamp_top dc=%0d at_target=%b exp 100/1", dc_out, at_target); end
        target = 7'd98;
        wait_change(7'd100, cyc, to);
        n_vec++; if (to || dc_out !== 7'd98 || at_target !== 1'b1) begin n_err++; $display("FAIL clamp_to_98 dc=%0d at_target=%b exp 98/1", dc_out, at_target); end
    endtask

    task automatic test_target_zero();
        logic [6:0] prev, last_nz;
        int cyc, n; bit to;
        target = 7'd0;
        prev = dc_out; last_nz = dc_out; n = 0;
        do begin
            wait_change(prev, cyc, to);
            if (dc_out !== 7'd0) last_nz = dc_out;
            prev = dc_out; n++;
        end while (dc_out !== 7'd0 && !to && n < 40);
        n_vec++; if (n != 25 || last_nz !== 7'd2) begin n_err++; $display("FAIL down_to_zero steps=%0d last=%0d exp 25/2", n, last_nz); end
        @(negedge clk);
        n_vec++; if (at_target !== 1'b1 || busy !== 1'b0 || dc_out !== 7'd0) begin n_err++; $display("FAIL zero_hold at_target=%b busy=%b dc=%0d exp 1/0/0", at_target, busy, dc_out); end
    endtask

    task automatic test_retarget();
        logic [6:0] prev, exp;
        logic [6:0] down_seq [4];
        int cyc; bit to;
        down_seq = '{7'd20, 7'd16, 7'd12, 7'd10};
        target = 7'd60;
        prev = 7'd0;
        for (int i = 1; i <= 6; i++) begin
            wait_change(prev, cyc, to);
            exp = 7'(4 * i);
            n_vec++; if (to || dc_out !== exp) begin n_err++; $display("FAIL retarget_up%0d got=%0d exp=%0d", i, dc_out, exp); end
            prev = dc_out;
        end
        target = 7'd10;
        for (int i = 0; i < 4; i++) begin
            wait_change(prev, cyc, to);
            n_vec++; if (to || dc_out !== down_seq[i]) begin n_err++; $display("FAIL retarget_down%0d got=%0d exp=%0d", i, dc_out, down_seq[i]); end
            prev = dc_out;
        end
        n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL retarget_hold got=%b exp=1", at_target); end
    endtask

    task automatic test_soft_stop();
        logic [6:0] prev;
        logic [6:0] stop_seq [3];
        int cyc; bit to;
        stop_seq = '{7'd6, 7'd2, 7'd0};
        en = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b1 || at_target !== 1'b0) begin n_err++; $display("FAIL stop_enter busy=%b at_target=%b exp 1/0", busy, at_target); end
        wait_change(7'd10, cyc, to);
        n_vec++; if (to || dc_out !== 7'd6) begin n_err++; $display("FAIL stop_first got=%0d exp=6", dc_out); end
        en = 1'b1;
        @(negedge clk);
        n_vec++; if (dc_out !== 7'd6 || busy !== 1'b1) begin n_err++; $display("FAIL rearm_no_jump dc=%0d busy=%b exp 6/1", dc_out, busy); end
        wait_change(7'd6, cyc, to);
        n_vec++; if (to || dc_out !== 7'd10 || at_target !== 1'b1) begin n_err++; $display("FAIL rearm_up dc=%0d at_target=%b exp 10/1", dc_out, at_target); end
        en = 1'b0;
        prev = 7'd10;
        for (int i = 0; i < 3; i++) begin
            wait_change(prev, cyc, to);
            n_vec++; if (to || dc_out !== stop_seq[i]) begin n_err++; $display("FAIL stop_step%0d got=%0d exp=%0d", i, dc_out, stop_seq[i]); end
            prev = dc_out;
        end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || at_target !== 1'b0 || fault_act !== 1'b0) begin n_err++; $display("FAIL stop_idle busy=%b at_target=%b fault_act=%b exp 0/0/0", busy, at_target, fault_act); end
    endtask

    task automatic test_fault();
        logic [6:0] prev;
        int cyc, n; bit to;
        en = 1'b1; target = 7'd50;
        prev = 7'd0; n = 0;
        do begin
            wait_change(prev, cyc, to);
            prev = dc_out; n++;
        end while (dc_out !== 7'd50 && !to && n < 20);
        n_vec++; if (n != 13 || dc_out !== 7'd50 || at_target !== 1'b1) begin n_err++; $display("FAIL fault_setup steps=%0d dc=%0d exp 13/50", n, dc_out); end
        fault = 1'b1;
        @(negedge clk);
        n_vec++; if (dc_out !== 7'd0 || fault_act !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL fault_entry dc=%0d fault_act=%b busy=%b exp 0/1/0", dc_out, fault_act, busy); end
        fault = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++; if (fault_act !== 1'b1 || dc_out !== 7'd0) begin n_err++; $display("FAIL fault_latched fault_act=%b dc=%0d exp 1/0", fault_act, dc_out); end
        en = 1'b0;
        @(negedge clk);
        n_vec++; if (fault_act !== 1'b0 || busy !== 1'b0 || at_target !== 1'b0) begin n_err++; $display("FAIL fault_exit fault_act=%b busy=%b at_target=%b exp 0/0/0", fault_act, busy, at_target); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] prev;
        int cyc, n; bit to;
        en = 1'b1; target = 7'd60;
        prev = 7'd0; n = 0;
        do begin
            wait_change(prev, cyc, to);
            prev = dc_out; n++;
        end while (dc_out !== 7'd32 && !to && n < 20);
        n_vec++; if (dc_out !== 7'd32 || busy !== 1'b1) begin n_err++; $display("FAIL reset_mid_setup dc=%0d busy=%b exp 32/1", dc_out, busy); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if (dc_out !== 7'd0 || busy !== 1'b0 || at_target !== 1'b0 || fault_act !== 1'b0) begin n_err++; $display("FAIL reset_mid dc=%0d busy=%b at_target=%b fault_act=%b exp all 0", dc_out, busy, at_target, fault_act); end
        reset = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fault_on_tick();
        int cyc; bit to;
        en = 1'b1; target = 7'd20;
        wait_change(7'd0, cyc, to);
        n_vec++; if (to || dc_out !== 7'd4) begin n_err++; $display("FAIL ftick_setup got=%0d exp=4", dc_out); end
        repeat (79) @(negedge clk);
        fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        n_vec++; if (dc_out !== 7'd0 || fault_act !== 1'b1) begin n_err++; $display("FAIL ftick_no_step dc=%0d fault_act=%b exp 0/1", dc_out, fault_act); end
        en = 1'b0;
        @(negedge clk);
        n_vec++; if (fault_act !== 1'b0 || dc_out !== 7'd0) begin n_err++; $display("FAIL ftick_exit fault_act=%b dc=%0d exp 0/0", fault_act, dc_out); end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; fault = 1'b0; target = 7'd0;
        test_reset();
        test_ramp_up();
        test_clamp();
        test_target_zero();
        test_retarget();
        test_soft_stop();
        test_fault();
        test_reset_mid();
        test_fault_on_tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
